proc_control_unit: RTL and testbench
====================================

Name: proc_control_unit

Overview:
- Instruction-sequencing FSM for the 16-bit datapath, directly upstream of the bus multiplexer.
- Latches an instruction word from DIN and steps it through time slots T0–T3.
- Drives the bus-source selects (Rout, Gout, DINout) consumed by the mux, plus register/ALU load strobes and Done.
- Supports mv, mvi, add and sub; sub is optional.

Parameters:
- DATA_WIDTH, 16, width of DIN; only DIN[IR_WIDTH-1:0] is used.
- IR_WIDTH, 9, instruction register width: opcode III = IR[8:6], X = IR[5:3], Y = IR[2:0].

Ports:
- Clock  input  1  single system clock, rising edge.
- Resetn  input  1  asynchronous, active-high reset (high = reset, despite name).
- Run  input  1  start request, sampled only in T0.
- DIN  input  DATA_WIDTH  instruction word in T0; immediate data in T1 of mvi.
- IRin  output  1  IR load strobe (informational; IR is held internally).
- Rout  output  8  one-hot bus source; bit 7 = R0 … bit 0 = R7; all-zero when not driving.
- Gout  output  1  put G on bus.
- DINout  output  1  put DIN on bus.
- Rin  output  8  one-hot register write enable; same bit ordering as Rout.
- Ain  output  1  load A from bus.
- Gin  output  1  load G from ALU.
- AddSub  output  1  ALU op: 0 = add, 1 = sub.
- Done  output  1  last step of instruction.
- Tstep  output  2  current time slot, 0..3 (debug/verification).

Behaviour:
- State register Tstep and IR are flops.
  - Asynchronous reset: Tstep = 0, IR = 0.
- All other outputs are combinational decodes of (Tstep, IR, Run).
  - While Resetn = 1, every output is 0, including IRin.
- Register indexing: register n maps to Rout/Rin bit (7-n).
- At most one of {Rout != 0, Gout, DINout} is asserted in any cycle; Rout stays zero while Gout or DINout is high.
- T0:
  - Run = 1: IRin = 1, IR <= DIN[8:0] on the clock edge, next state T1.
  - Run = 0: all outputs 0, stay in T0, IR holds.
- T1, by opcode:
  - 000 mv Rx,Ry: Rout = bit Y, Rin = bit X, Done = 1, next T0.
  - 001 mvi Rx,#D: DINout = 1, Rin = bit X, Done = 1, next T0.
  - 010 add / 011 sub: Rout = bit X, Ain = 1, next T2.
  - 100–111 reserved: Done = 1, no other strobe, next T0.
- T2, add/sub only: Rout = bit Y, Gin = 1, AddSub = (opcode == 011), next T3.
- T3, add/sub only: Gout = 1, Rin = bit X, Done = 1, next T0.
- Latency:
  - mv and mvi: 2 cycles from Run sample to Done cycle inclusive.
  - add and sub: 4 cycles.
- Run while Tstep != 0 is ignored; there is no queuing.
  - Run high in the Done cycle starts nothing.
  - A new fetch occurs only on the following cycle in T0.
- Run held high continuously gives back-to-back instructions:
  - T0 fetch follows each Done cycle.
  - DIN is sampled fresh each T0.
- X == Y is legal; e.g. add R3,R3 reads R3 twice and writes back.
- Reset asserted mid-instruction:
  - Outputs drop to 0 immediately, with no clock needed.
  - After release, the FSM is in T0 with IR = 0; the aborted instruction is not resumed.
- Tstep value 3 occurs only for add/sub. An unreachable state encoding falls back to T0 on the next edge.

Optional Feature:
- Macro: PROC_CU_SUB_EN.
- Defined: opcode 011 executes sub as above, with AddSub = 1 in T2.
- Undefined: opcode 011 decodes as reserved.
  - T1 asserts Done only, then T0.
  - AddSub is tied 0.

Test Plan:
- Reset then release with Run = 0 for 5 cycles -> Tstep = 0; all outputs 0 every cycle.
- Run = 1, DIN = 0x00A (mv R1,R2) -> T0: IRin = 1. T1: Rout = 0x20, Rin = 0x40, Done = 1. Then Tstep = 0.
- Run = 1, DIN = 0x058 (mvi R3), next cycle DIN = 0x1234 -> T1: DINout = 1, Rin = 0x10, Rout = 0x00, Done = 1.
- Run = 1, DIN = 0x08D (add R1,R5):
  - T1: Rout = 0x40, Ain = 1.
  - T2: Rout = 0x04, Gin = 1, AddSub = 0.
  - T3: Gout = 1, Rin = 0x40, Done = 1.
- DIN = 0x0C0 (sub R0,R0):
  - With PROC_CU_SUB_EN: T2 has AddSub = 1, Rout = 0x80; Done in T3.
  - Without it: Done in T1, no Ain.
- Start add, assert Resetn in T2 -> outputs 0 asynchronously. After release with Run = 0: Tstep = 0, no Done pulse; Run pulses during T1–T3 produce no extra fetch.

Source files
------------

// File: rtl/proc_control_unit.sv
// ============================================================================
// Module   : proc_control_unit
// Purpose  : Instruction-sequencing FSM for the 16-bit datapath. It latches an
//            instruction from DIN in T0 and steps it through T1..T3. Each slot
//            drives the bus-source selects, register/ALU load strobes and Done.
// Options  : PROC_CU_SUB_EN -- when defined, opcode 011 executes sub.
//            When undefined, opcode 011 is reserved and AddSub is tied low.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module proc_control_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int IR_WIDTH   = 9
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  Run,
  input  logic [DATA_WIDTH-1:0] DIN,
  output logic                  IRin,
  output logic [7:0]            Rout,
  output logic                  Gout,
  output logic                  DINout,
  output logic [7:0]            Rin,
  output logic                  Ain,
  output logic                  Gin,
  output logic                  AddSub,
  output logic                  Done,
  output logic [1:0]            Tstep
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } tstep_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  tstep_t                state;
  logic [IR_WIDTH-1:0]   ir;
  logic [2:0]            opcode;
  logic [2:0]            reg_x;
  logic [2:0]            reg_y;
  logic                  is_sub;
  logic                  is_alu;

  // Only the low IR_WIDTH bits of DIN carry an instruction; the rest is
  // folded into a sink so it does not look like an accidental dangling input.
  generate
    if (DATA_WIDTH > IR_WIDTH) begin : g_din_hi_sink
      logic unused_din_hi;
      assign unused_din_hi = ^DIN[DATA_WIDTH-1:IR_WIDTH];
    end
  endgenerate

  assign opcode = ir[8:6];
  assign reg_x  = ir[5:3];
  assign reg_y  = ir[2:0];

`ifdef PROC_CU_SUB_EN
  assign is_sub = (opcode == OP_SUB);
`else
  assign is_sub = 1'b0;
`endif
  assign is_alu = (opcode == OP_ADD) || is_sub;

  // Register n sits at bit (7-n): R0 is the MSB of Rout/Rin.
  function automatic logic [7:0] reg_onehot(input logic [2:0] idx);
    return 8'b1000_0000 >> idx;
  endfunction

  // Time-slot sequencer and instruction register.
  always_ff @(posedge Clock or posedge Resetn) begin
    if (Resetn) begin
      state <= T0;
      ir    <= '0;
    end else begin
      case (state)
        T0: begin
          if (Run) begin
            ir    <= DIN[IR_WIDTH-1:0];
            state <= T1;
          end
        end
        T1:      state <= is_alu ? T2 : T0;
        T2:      state <= is_alu ? T3 : T0;
        T3:      state <= T0;
        default: state <= T0;
      endcase
    end
  end

  // Per-slot output decode. Reset forces every output low without a clock.
  always_comb begin
    IRin   = 1'b0;
    Rout   = 8'h00;
    Gout   = 1'b0;
    DINout = 1'b0;
    Rin    = 8'h00;
    Ain    = 1'b0;
    Gin    = 1'b0;
    AddSub = 1'b0;
    Done   = 1'b0;
    if (!Resetn) begin
      case (state)
        T0: begin
          IRin = Run;
        end
        T1: begin
          if (opcode == OP_MV) begin
            Rout = reg_onehot(reg_y);
            Rin  = reg_onehot(reg_x);
            Done = 1'b1;
          end else if (opcode == OP_MVI) begin
            DINout = 1'b1;
            Rin    = reg_onehot(reg_x);
            Done   = 1'b1;
          end else if (is_alu) begin
            Rout = reg_onehot(reg_x);
            Ain  = 1'b1;
          end else begin
            // Reserved opcodes retire immediately with no side effects.
            Done = 1'b1;
          end
        end
        T2: begin
          if (is_alu) begin
            Rout   = reg_onehot(reg_y);
            Gin    = 1'b1;
            AddSub = is_sub;
          end
        end
        T3: begin
          if (is_alu) begin
            Gout = 1'b1;
            Rin  = reg_onehot(reg_x);
            Done = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Tstep = state;

endmodule

`default_nettype wire

// File: tb/tb_proc_control_unit.sv
// ============================================================================
// Module   : tb_proc_control_unit
// Purpose  : Directed self-checking bench for proc_control_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_proc_control_unit;

  logic        Clock;
  logic        Resetn;
  logic        Run;
  logic [15:0] DIN;
  logic        IRin;
  logic [7:0]  Rout;
  logic        Gout;
  logic        DINout;
  logic [7:0]  Rin;
  logic        Ain;
  logic        Gin;
  logic        AddSub;
  logic        Done;
  logic [1:0]  Tstep;

  int checks   = 0;
  int failures = 0;

  logic [24:0] obs;
  assign obs = {IRin, Rout, Gout, DINout, Rin, Ain, Gin, AddSub, Done, Tstep};

  proc_control_unit #(
    .DATA_WIDTH(16),
    .IR_WIDTH  (9)
  ) dut (
    .Clock (Clock),
    .Resetn(Resetn),
    .Run   (Run),
    .DIN   (DIN),
    .IRin  (IRin),
    .Rout  (Rout),
    .Gout  (Gout),
    .DINout(DINout),
    .Rin   (Rin),
    .Ain   (Ain),
    .Gin   (Gin),
    .AddSub(AddSub),
    .Done  (Done),
    .Tstep (Tstep)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Pack expected outputs in the same order as obs.
  function automatic logic [24:0] ex(input logic irin, input logic [7:0] rout,
                                     input logic gout, input logic dinout,
                                     input logic [7:0] rin, input logic ain,
                                     input logic gin, input logic addsub,
                                     input logic done, input logic [1:0] ts);
    return {irin, rout, gout, dinout, rin, ain, gin, addsub, done, ts};
  endfunction

  localparam logic [24:0] IDLE = 25'd0;

  task automatic chk(input string tag, input logic [24:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Advance to just after the next rising edge, then apply inputs.
  task automatic cyc(input logic run, input logic [15:0] din);
    @(posedge Clock);
    #1;
    Run = run;
    DIN = din;
    #1;
  endtask

  initial begin
    Resetn = 1'b1;
    Run    = 1'b1;
    DIN    = 16'h000A;
    #2;
    chk("reset_outputs_low", IDLE);
    cyc(1'b1, 16'h000A);
    chk("reset_held_over_edge", IDLE);

    // Release reset and idle for five cycles.
    @(posedge Clock);
    #1;
    Resetn = 1'b0;
    Run    = 1'b0;
    DIN    = 16'h0000;
    #1;
    chk("idle_after_release", IDLE);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 16'h0000);
      chk("idle_run_low", IDLE);
    end

    // mv R1,R2
    cyc(1'b1, 16'h000A);
    chk("mv_t0", ex(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 2'd0));
    cyc(1'b0, 16'h0000);
    chk("mv_t1", ex(0, 8'h20, 0, 0, 8'h40, 0, 0, 0, 1, 2'd1));
    cyc(1'b0, 16'h0000);
    chk("mv_back_t0", IDLE);

    // mvi R3,#0x1234
    cyc(1'b1, 16'h0058);
    chk("mvi_t0", ex(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 2'd0));
    cyc(1'b0, 16'h1234);
    chk("mvi_t1", ex(0, 8'h00, 0, 1, 8'h10, 0, 0, 0, 1, 2'd1));
    cyc(1'b0, 16'h0000);
    chk("mvi_back_t0", IDLE);

    // add R1,R5
    cyc(1'b1, 16'h008D);
    chk("add_t0", ex(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 2'd0));
    cyc(1'b0, 16'h0000);
    chk("add_t1", ex(0, 8'h40, 0, 0, 8'h00, 1, 0, 0, 0, 2'd1));
    cyc(1'b0, 16'h0000);
    chk("add_t2", ex(0, 8'h04, 0, 0, 8'h00, 0, 1, 0, 0, 2'd2));
    cyc(1'b0, 16'h0000);
    chk("add_t3", ex(0, 8'h00, 1, 0, 8'h40, 0, 0, 0, 1, 2'd3));
    cyc(1'b0, 16'h0000);
    chk("add_back_t0", IDLE);

    // Run held high: Done cycle starts nothing, next T0 fetches fresh DIN.
    cyc(1'b1, 16'h000A);
    chk("b2b_mv_t0", ex(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 2'd0));
    cyc(1'b1, 16'h0058);
    chk("b2b_mv_t1_run_ignored", ex(0, 8'h20, 0, 0, 8'h40, 0, 0, 0, 1, 2'd1));
    cyc(1'b1, 16'h0058);
    chk("b2b_mvi_t0", ex(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 2'd0));
    cyc(1'b0, 16'h0000);
    chk("b2b_mvi_t1", ex(0, 8'h00, 0, 1, 8'h10, 0, 0, 0, 1, 2'd1));
    cyc(1'b0, 16'h0000);
    chk("b2b_back_t0", IDLE);

    // sub R0,R0
    cyc(1'b1, 16'h00C0);
    chk("sub_t0", ex(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 2'd0));
`ifdef PROC_CU_SUB_EN
    cyc(1'b0, 16'h0000);
    chk("sub_t1", ex(0, 8'h80, 0, 0, 8'h00, 1, 0, 0, 0, 2'd1));
    cyc(1'b0, 16'h0000);
    chk("sub_t2", ex(0, 8'h80, 0, 0, 8'h00, 0, 1, 1, 0, 2'd2));
    cyc(1'b0, 16'h0000);
    chk("sub_t3", ex(0, 8'h00, 1, 0, 8'h80, 0, 0, 0, 1, 2'd3));
`else
    cyc(1'b0, 16'h0000);
    chk("sub_reserved_t1", ex(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 2'd1));
`endif
    cyc(1'b0, 16'h0000);
    chk("sub_back_t0", IDLE);

    // Reserved opcode 111
    cyc(1'b1, 16'h01FF);
    chk("rsv_t0", ex(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 2'd0));
    cyc(1'b0, 16'h0000);
    chk("rsv_t1", ex(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 2'd1));
    cyc(1'b0, 16'h0000);
    chk("rsv_back_t0", IDLE);

    // add R3,R3 (X == Y)
    cyc(1'b1, 16'h009B);
    cyc(1'b0, 16'h0000);
    chk("addxx_t1", ex(0, 8'h10, 0, 0, 8'h00, 1, 0, 0, 0, 2'd1));
    cyc(1'b0, 16'h0000);
    chk("addxx_t2", ex(0, 8'h10, 0, 0, 8'h00, 0, 1, 0, 0, 2'd2));
    cyc(1'b0, 16'h0000);
    chk("addxx_t3", ex(0, 8'h00, 1, 0, 8'h10, 0, 0, 0, 1, 2'd3));
    cyc(1'b0, 16'h0000);
    chk("addxx_back_t0", IDLE);

    // Reset asserted during T2 of an add.
    cyc(1'b1, 16'h008D);
    cyc(1'b0, 16'h0000);
    cyc(1'b0, 16'h0000);
    chk("abort_pre_t2", ex(0, 8'h04, 0, 0, 8'h00, 0, 1, 0, 0, 2'd2));
    Resetn = 1'b1;
    #1;
    chk("abort_async_low", IDLE);
    cyc(1'b0, 16'h0000);
    chk("abort_held", IDLE);
    @(posedge Clock);
    #1;
    Resetn = 1'b0;
    #1;
    chk("abort_release", IDLE);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 16'h0000);
      chk("abort_no_resume", IDLE);
    end

    // Run pulses during T1..T3 must not fetch.
    cyc(1'b1, 16'h008D);
    chk("pulse_t0", ex(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 2'd0));
    cyc(1'b1, 16'h000A);
    chk("pulse_t1", ex(0, 8'h40, 0, 0, 8'h00, 1, 0, 0, 0, 2'd1));
    cyc(1'b1, 16'h000A);
    chk("pulse_t2", ex(0, 8'h04, 0, 0, 8'h00, 0, 1, 0, 0, 2'd2));
    cyc(1'b1, 16'h000A);
    chk("pulse_t3", ex(0, 8'h00, 1, 0, 8'h40, 0, 0, 0, 1, 2'd3));
    cyc(1'b0, 16'h000A);
    chk("pulse_back_t0", IDLE);
    cyc(1'b0, 16'h000A);
    chk("pulse_still_idle", IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
